mult_arbiter: RTL and testbench

Round-robin arbiter and sequencer that shares one sequential shift-add 8x8 multiplier among NREQ requesters. It accepts level requests carrying operand pairs and grants one requester at a time. It drives the multiplier's load/operand inputs, waits for its done flag, and returns the 16-bit product with a one-cycle ack to the granted requester. It sits between the CPU functional units that need multiplication and the single multiplier instance.

---
 rtl/mult_arbiter.sv | 178 +++++++++++++++++
 tb/tb_mult_arbiter.sv | 388 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mult_arbiter.sv
// Round-robin arbiter/sequencer sharing one sequential shift-add multiplier among NREQ
// requesters. Grants one requester at a time, strobes the multiplier, waits for its done
// flag and returns the product with a one-cycle ack.
// Optional feature: define MULT_ARB_TIMEOUT_EN to abort a WAIT that lasts TIMEOUT cycles
// (ack with err=1 and result=0). Without it WAIT is unbounded and err is constant 0.
module mult_arbiter #(
    parameter int unsigned NREQ    = 4,
    parameter int unsigned W       = 8,
    parameter int unsigned TIMEOUT = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [NREQ-1:0]   req,
    input  logic [NREQ*W-1:0] op_a,
    input  logic [NREQ*W-1:0] op_b,
    output logic [NREQ-1:0]   ack,
    output logic [2*W-1:0]    result,
    output logic              err,
    output logic              busy,
    output logic              mul_ld,
    output logic [W-1:0]      mul_a,
    output logic [W-1:0]      mul_b,
    input  logic [2*W-1:0]    mul_o,
    input  logic              mul_done
);

    localparam int unsigned IW = (NREQ > 1) ? $clog2(NREQ) : 1;

    typedef enum logic [1:0] {
        StIdle,
        StLoad,
        StWait,
        StResp
    } state_e;

    state_e         state_q, state_d;
    logic [IW-1:0]  grant_q, grant_d;
    logic [IW-1:0]  last_q, last_d;
    logic [W-1:0]   mul_a_q, mul_a_d;
    logic [W-1:0]   mul_b_q, mul_b_d;
    logic [2*W-1:0] result_q, result_d;
    logic           first_q, first_d;  // high during the first WAIT cycle
    logic           err_q, err_d;

    logic           sel_valid;
    logic [IW-1:0]  sel_idx;
    logic [IW-1:0]  cand;
    logic           timeout;

    // Round-robin pick: first requester at or after last+1, wrapping around.
    always_comb begin
        sel_valid = 1'b0;
        sel_idx   = '0;
        cand      = '0;
        for (int unsigned k = 1; k <= NREQ; k++) begin
            cand = IW'((32'(last_q) + k) % NREQ);
            if (!sel_valid && req[cand]) begin
                sel_valid = 1'b1;
                sel_idx   = cand;
            end
        end
    end

`ifdef MULT_ARB_TIMEOUT_EN
    localparam int unsigned CW = $clog2(TIMEOUT + 1);

    logic [CW-1:0] cnt_q, cnt_d;

    // WAIT-cycle counter: cleared when entering WAIT, counts every WAIT cycle.
    always_comb begin
        cnt_d = cnt_q;
        if (state_q == StLoad) begin
            cnt_d = '0;
        end else if (state_q == StWait) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    // Counter register.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign timeout = (state_q == StWait) && (cnt_q == CW'(TIMEOUT - 1));
`else
    logic unused_timeout;
    assign unused_timeout = ^32'(TIMEOUT);
    assign timeout        = 1'b0;
`endif

    // Sequencer next-state logic.
    always_comb begin
        state_d  = state_q;
        grant_d  = grant_q;
        last_d   = last_q;
        mul_a_d  = mul_a_q;
        mul_b_d  = mul_b_q;
        result_d = result_q;
        first_d  = first_q;
        err_d    = err_q;
        unique case (state_q)
            StIdle: begin
                if (sel_valid) begin
                    grant_d = sel_idx;
                    mul_a_d = op_a[32'(sel_idx) * W +: W];
                    mul_b_d = op_b[32'(sel_idx) * W +: W];
                    state_d = StLoad;
                end
            end
            StLoad: begin
                first_d = 1'b1;
                state_d = StWait;
            end
            StWait: begin
                first_d = 1'b0;
                // A done seen in the first WAIT cycle may be left over from the last operation.
                if (!first_q && mul_done) begin
                    result_d = mul_o;
                    err_d    = 1'b0;
                    state_d  = StResp;
                end else if (timeout) begin
                    result_d = '0;
                    err_d    = 1'b1;
                    state_d  = StResp;
                end
            end
            StResp: begin
                last_d  = grant_q;
                err_d   = 1'b0;
                state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    // State and datapath registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= StIdle;
            grant_q  <= '0;
            last_q   <= IW'(NREQ - 1);
            mul_a_q  <= '0;
            mul_b_q  <= '0;
            result_q <= '0;
            first_q  <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            grant_q  <= grant_d;
            last_q   <= last_d;
            mul_a_q  <= mul_a_d;
            mul_b_q  <= mul_b_d;
            result_q <= result_d;
            first_q  <= first_d;
            err_q    <= err_d;
        end
    end

    // One-hot ack to the granted requester during RESP.
    always_comb begin
        ack = '0;
        if (state_q == StResp) begin
            ack[grant_q] = 1'b1;
        end
    end

    assign result = result_q;
    assign err    = err_q;
    assign busy   = (state_q != StIdle);
    assign mul_ld = (state_q == StLoad);
    assign mul_a  = mul_a_q;
    assign mul_b  = mul_b_q;

endmodule

// File: tb/tb_mult_arbiter.sv
// Self-checking bench for mult_arbiter: table of single requests, then contention,
// withdrawal, stale-done, mid-operation reset and (with MULT_ARB_TIMEOUT_EN) timeout.
module tb_mult_arbiter;

    localparam int NREQ = 4;
    localparam int W    = 8;
    localparam int TMO  = 32;

    logic              clk = 1'b0;
    logic              rst;
    logic [NREQ-1:0]   req;
    logic [NREQ*W-1:0] op_a;
    logic [NREQ*W-1:0] op_b;
    logic [NREQ-1:0]   ack;
    logic [2*W-1:0]    result;
    logic              err;
    logic              busy;
    logic              mul_ld;
    logic [W-1:0]      mul_a;
    logic [W-1:0]      mul_b;
    logic [2*W-1:0]    mul_o;
    logic              mul_done;

    mult_arbiter #(
        .NREQ   (NREQ),
        .W      (W),
        .TIMEOUT(TMO)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .req     (req),
        .op_a    (op_a),
        .op_b    (op_b),
        .ack     (ack),
        .result  (result),
        .err     (err),
        .busy    (busy),
        .mul_ld  (mul_ld),
        .mul_a   (mul_a),
        .mul_b   (mul_b),
        .mul_o   (mul_o),
        .mul_done(mul_done)
    );

    always #5 clk = ~clk;

    // Multiplier model: done goes high m_lat cycles after the load and stays high until
    // the next load. In manual mode the bench drives done/product directly.
    int             m_lat = 3;
    int             m_cnt;
    logic           m_run;
    logic           m_done;
    logic [2*W-1:0] m_o;
    logic [W-1:0]   m_pa, m_pb;
    logic           manual;
    logic           man_done;
    logic [2*W-1:0] man_o;

    always @(posedge clk) begin
        if (rst) begin
            m_run  <= 1'b0;
            m_done <= 1'b0;
            m_o    <= '0;
            m_cnt  <= 0;
        end else if (mul_ld) begin
            m_run  <= 1'b1;
            m_done <= 1'b0;
            m_cnt  <= m_lat;
            m_pa   <= mul_a;
            m_pb   <= mul_b;
        end else if (m_run) begin
            if (m_cnt <= 1) begin
                m_done <= 1'b1;
                m_o    <= 16'(m_pa) * 16'(m_pb);
                m_run  <= 1'b0;
            end else begin
                m_cnt <= m_cnt - 1;
            end
        end
    end

    assign mul_done = manual ? man_done : m_done;
    assign mul_o    = manual ? man_o : m_o;

    typedef struct {
        int          idx;
        logic [15:0] prod;
        logic        err;
    } sb_t;

    typedef struct {
        int          idx;
        logic [7:0]  a;
        logic [7:0]  b;
        logic [15:0] prod;
    } vec_t;

    sb_t  q[$];
    vec_t vecs[6];
    int   checks = 0;
    int   errors = 0;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at %0t",
                     name, got, got, exp, exp, $time);
        end
    endtask

    // Scoreboard: every ack pops the oldest expected completion.
    initial begin
        sb_t e;
        forever begin
            @(negedge clk);
            if (ack !== '0) begin
                if (q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL ack_unexpected: ack=%b with nothing expected at %0t", ack, $time);
                end else begin
                    e = q.pop_front();
                    chk("ack_onehot", 32'(ack), 32'(4'b0001 << e.idx));
                    chk("ack_result", 32'(result), 32'(e.prod));
                    chk("ack_err", 32'(err), 32'(e.err));
                end
            end
        end
    end

    task automatic push(input int idx, input logic [15:0] prod, input logic e);
        sb_t s;
        s.idx  = idx;
        s.prod = prod;
        s.err  = e;
        q.push_back(s);
    endtask

    task automatic wait_ld(input string name);
        int n = 0;
        while (mul_ld !== 1'b1 && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk(name, 32'(mul_ld), 32'd1);
    endtask

    task automatic wait_drain(input string name, input int budget);
        int n = 0;
        while (q.size() != 0 && n < budget) begin
            @(negedge clk);
            #1;
            n++;
        end
        chk(name, 32'(q.size()), 32'd0);
        q.delete();
    endtask

    task automatic apply_reset();
        @(posedge clk);
        #1;
        rst = 1'b1;
        req = '0;
        @(posedge clk);
        #1;
        rst = 1'b0;
        q.delete();
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_ack"}, 32'(ack), 32'd0);
        chk({tag, "_result"}, 32'(result), 32'd0);
        chk({tag, "_err"}, 32'(err), 32'd0);
        chk({tag, "_busy"}, 32'(busy), 32'd0);
        chk({tag, "_mul_ld"}, 32'(mul_ld), 32'd0);
        chk({tag, "_mul_a"}, 32'(mul_a), 32'd0);
        chk({tag, "_mul_b"}, 32'(mul_b), 32'd0);
    endtask

    task automatic run_single(input vec_t v);
        @(posedge clk);
        #1;
        op_a[v.idx*W +: W] = v.a;
        op_b[v.idx*W +: W] = v.b;
        push(v.idx, v.prod, 1'b0);
        req = '0;
        req[v.idx] = 1'b1;
        @(negedge clk);
        chk("single_ld_not_early", 32'(mul_ld), 32'd0);
        @(negedge clk);
        chk("single_ld_pulse", 32'(mul_ld), 32'd1);
        chk("single_mul_a", 32'(mul_a), 32'(v.a));
        chk("single_mul_b", 32'(mul_b), 32'(v.b));
        @(negedge clk);
        chk("single_ld_one_cycle", 32'(mul_ld), 32'd0);
        wait_drain("single_drain", 40);
        @(posedge clk);
        #1;
        req = '0;
        @(negedge clk);
        chk("single_busy_low", 32'(busy), 32'd0);
    endtask

    initial begin
        vecs[0] = '{idx: 1, a: 8'd13,  b: 8'd11,  prod: 16'd143};
        vecs[1] = '{idx: 0, a: 8'd0,   b: 8'd77,  prod: 16'd0};
        vecs[2] = '{idx: 3, a: 8'd255, b: 8'd255, prod: 16'd65025};
        vecs[3] = '{idx: 2, a: 8'd1,   b: 8'd200, prod: 16'd200};
        vecs[4] = '{idx: 0, a: 8'd128, b: 8'd2,   prod: 16'd256};
        vecs[5] = '{idx: 3, a: 8'd16,  b: 8'd16,  prod: 16'd256};

        rst      = 1'b1;
        req      = '0;
        op_a     = '0;
        op_b     = '0;
        manual   = 1'b0;
        man_done = 1'b0;
        man_o    = '0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        chk_zero("reset");

        // Single requests from the table.
        for (int i = 0; i < 6; i++) begin
            run_single(vecs[i]);
        end

        // Contention: all four held, round-robin from requester 0 after reset.
        apply_reset();
        op_a = {8'd255, 8'd200, 8'd12, 8'd3};
        op_b = {8'd255, 8'd100, 8'd10, 8'd5};
        push(0, 16'd15, 1'b0);
        push(1, 16'd120, 1'b0);
        push(2, 16'd20000, 1'b0);
        push(3, 16'd65025, 1'b0);
        push(0, 16'd15, 1'b0);
        req = 4'b1111;
        wait_drain("contention_drain", 200);
        @(posedge clk);
        #1;
        req = '0;
        repeat (6) @(negedge clk);

        // Withdrawal: 0 and 1 drop while 0 is in WAIT; 0 still acked, 1 never served,
        // then 2 drops during its own WAIT and is still acked.
        apply_reset();
        m_lat = 6;
        op_a = {8'd0, 8'd21, 8'd9, 8'd6};
        op_b = {8'd0, 8'd12, 8'd9, 8'd7};
        push(0, 16'd42, 1'b0);
        push(2, 16'd252, 1'b0);
        req = 4'b0111;
        wait_ld("withdraw_ld0");
        chk("withdraw_grant0_a", 32'(mul_a), 32'd6);
        @(posedge clk);
        #1;
        req = 4'b0100;
        @(negedge clk);
        wait_ld("withdraw_ld2");
        chk("withdraw_grant2_a", 32'(mul_a), 32'd21);
        @(posedge clk);
        #1;
        req = '0;
        wait_drain("withdraw_drain", 60);
        repeat (8) @(negedge clk);

        // Stale done held into the first WAIT cycle must be ignored.
        m_lat    = 3;
        manual   = 1'b1;
        man_done = 1'b1;
        man_o    = 16'hdead;
        @(posedge clk);
        #1;
        op_a[15:8] = 8'd7;
        op_b[15:8] = 8'd9;
        push(1, 16'd63, 1'b0);
        req = 4'b0010;
        wait_ld("stale_ld");
        @(posedge clk);
        #1;
        @(posedge clk);
        #1;
        man_done = 1'b0;
        begin
            int early = 0;
            for (int i = 0; i < 5; i++) begin
                @(negedge clk);
                if (ack !== '0 || busy !== 1'b1) early++;
            end
            chk("stale_no_early_ack", 32'(early), 32'd0);
        end
        @(posedge clk);
        #1;
        man_o    = 16'd63;
        man_done = 1'b1;
        @(posedge clk);
        #1;
        man_done = 1'b0;
        man_o    = 16'hbeef;
        wait_drain("stale_drain", 10);
        @(posedge clk);
        #1;
        req    = '0;
        manual = 1'b0;
        repeat (4) @(negedge clk);

        // Reset in WAIT: no ack, everything cleared, then requester 0 first.
        @(posedge clk);
        #1;
        op_a[15:8] = 8'd100;
        op_b[15:8] = 8'd3;
        req = 4'b0010;
        wait_ld("rstwait_ld");
        @(posedge clk);
        #1;
        rst = 1'b1;
        req = '0;
        @(posedge clk);
        #1;
        rst = 1'b0;
        q.delete();
        @(negedge clk);
        chk_zero("rstwait");
        @(posedge clk);
        #1;
        op_a = {8'd250, 8'd0, 8'd0, 8'd2};
        op_b = {8'd4, 8'd0, 8'd0, 8'd3};
        push(0, 16'd6, 1'b0);
        push(3, 16'd1000, 1'b0);
        req = 4'b1001;
        wait_ld("rstwait_ld0");
        @(posedge clk);
        #1;
        req = 4'b1000;
        wait_drain("rstwait_drain", 60);
        @(posedge clk);
        #1;
        req = '0;
        repeat (4) @(negedge clk);

`ifdef MULT_ARB_TIMEOUT_EN
        // Timeout: done never comes; ack with err after TMO WAIT cycles.
        manual   = 1'b1;
        man_done = 1'b0;
        man_o    = 16'h1234;
        @(posedge clk);
        #1;
        op_a[7:0] = 8'd5;
        op_b[7:0] = 8'd5;
        push(0, 16'd0, 1'b1);
        req = 4'b0001;
        wait_ld("timeout_ld");
        begin
            int n = 0;
            while (ack === '0 && n < 100) begin
                @(negedge clk);
                n++;
            end
            chk("timeout_cycles", 32'(n), 32'(TMO + 1));
        end
        @(posedge clk);
        #1;
        manual      = 1'b0;
        op_a[15:8]  = 8'd11;
        op_b[15:8]  = 8'd11;
        push(1, 16'd121, 1'b0);
        req = 4'b0010;
        wait_drain("timeout_next_drain", 60);
        @(posedge clk);
        #1;
        req = '0;
        repeat (4) @(negedge clk);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

endmodule
